// File: rtl/gru_seq_pkg.sv
// Shared types and helpers for the GRU sequence controller.
package gru_seq_pkg;

    // Default fixed-point data width used by the element typedef.
    localparam int GRU_WIDTH = 16;

    // Signed fixed-point vector element.
    typedef logic signed [GRU_WIDTH-1:0] gru_fx_t;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } gru_seq_state_e;

    // Width of a counter that must hold 0..seq_len inclusive.
    function automatic int step_cnt_w(input int seq_len);
        return (seq_len < 1) ? 1 : $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/gru_sequence_ctrl.sv
// GRU time-sequencer: accepts one x_t per step, presents x_t and h_{t-1} to an
// external GRU cell, captures h_t after the cell latency and feeds it back.
// Emits the final hidden state of each sequence downstream.
// Build option: define GRU_SEQ_RETURN_SEQUENCES_EN to emit every h_t instead
// of only the last one (out_last still marks the final step).
module gru_sequence_ctrl
    import gru_seq_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NFRAC        = 12,
    parameter int X_SIZE       = 8,
    parameter int H_SIZE       = 8,
    parameter int SEQ_LEN      = 4,
    parameter int CELL_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [WIDTH-1:0]           in_x        [0:X_SIZE-1],
    output logic signed [WIDTH-1:0]           cell_x      [0:X_SIZE-1],
    output logic signed [WIDTH-1:0]           cell_h_prev [0:H_SIZE-1],
    input  logic signed [WIDTH-1:0]           cell_h      [0:H_SIZE-1],
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [WIDTH-1:0]           out_h       [0:H_SIZE-1],
    output logic                              out_last,
    output logic [step_cnt_w(SEQ_LEN)-1:0]    seq_step
);

    localparam int SW    = step_cnt_w(SEQ_LEN);
    localparam int LAT_W = (CELL_LATENCY < 1) ? 1 : $clog2(CELL_LATENCY + 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_EMIT = ST_EMIT;

    // Elaboration-time sanity checks on the configuration.
    if (SEQ_LEN < 1) begin : g_seq_len_chk
        $error("gru_sequence_ctrl: SEQ_LEN must be >= 1");
    end
    if (CELL_LATENCY < 0) begin : g_lat_chk
        $error("gru_sequence_ctrl: CELL_LATENCY must be >= 0");
    end
    if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_nfrac_chk
        $error("gru_sequence_ctrl: NFRAC must lie in [0, WIDTH)");
    end

    logic [1:0]             state_q, state_d;
    logic [LAT_W-1:0]       lat_cnt_q;
    logic [SW-1:0]          seq_step_q;
    logic signed [WIDTH-1:0] x_reg [0:X_SIZE-1];
    logic signed [WIDTH-1:0] h_reg [0:H_SIZE-1];

    logic          accept;
    logic          capture;
    logic          emit_done;
    logic          at_final;
    logic          seq_done;
    logic [SW-1:0] step_next;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign capture   = (state_q == S_WAIT) && (lat_cnt_q == '0);
    assign emit_done = (state_q == S_EMIT) && out_ready;
    assign at_final  = (seq_step_q == SW'(SEQ_LEN));
    assign seq_done  = emit_done && at_final;
    assign step_next = seq_step_q + SW'(1);

    // Next-state decode for the IDLE -> WAIT -> (EMIT) -> IDLE loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == '0) begin
`ifdef GRU_SEQ_RETURN_SEQUENCES_EN
                    state_d = S_EMIT;
`else
                    state_d = (step_next == SW'(SEQ_LEN)) ? S_EMIT : S_IDLE;
`endif
                end
            end
            S_EMIT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: state, cell-latency countdown and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= '0;
            seq_step_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_cnt_q <= LAT_W'(CELL_LATENCY);
            end else if ((state_q == S_WAIT) && (lat_cnt_q != '0)) begin
                lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            end
            if (capture) begin
                seq_step_q <= step_next;
            end else if (seq_done) begin
                seq_step_q <= '0;
            end
        end
    end

    // Data registers: x_t held for the cell, h_t captured and fed back;
    // the hidden state returns to zero once a sequence has been delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= '{default: '0};
            h_reg <= '{default: '0};
        end else begin
            if (accept) begin
                x_reg <= in_x;
            end
            if (capture) begin
                h_reg <= cell_h;
            end else if (seq_done) begin
                h_reg <= '{default: '0};
            end
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_EMIT);
    assign out_last    = out_valid && at_final;
    assign out_h       = h_reg;
    assign cell_x      = x_reg;
    assign cell_h_prev = h_reg;
    assign seq_step    = seq_step_q;

endmodule
